// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage forwarding mux and the iterative RV32M unit.
package ex_muldiv_pkg;

  localparam logic [1:0] FWD_ID_EX  = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_md_iter_core.sv
// One-bit-per-cycle shift/add (multiply) or restoring shift/subtract (divide)
// datapath on unsigned magnitudes; {hi,lo} is product, or remainder/quotient.
module md_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] lo_init_i,
  input  logic [XLEN-1:0] m_init_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q, lo_q, m_q;
  logic            div_q;
  logic [XLEN:0]   sum_d, shl_d, diff_d;

  assign sum_d  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign shl_d  = {hi_q, lo_q[XLEN-1]};
  assign diff_d = shl_d - {1'b0, m_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= lo_init_i;
      m_q   <= m_init_i;
      div_q <= div_i;
    end else if (step_i) begin
      if (div_q) begin
        // Remainder stays below the divisor, so diff fits and its top bit is the borrow.
        if (!diff_d[XLEN]) begin
          hi_q <= diff_d[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= shl_d[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= sum_d[XLEN:1];
        lo_q <= {sum_d[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage operand forwarding mux plus iterative RV32M multiply/divide with
// pipeline stall control; operands are captured once at start.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] id_ex_rs1_data,
  input  logic [XLEN-1:0] id_ex_rs2_data,
  input  logic [XLEN-1:0] me_alu_result,
  input  logic [XLEN-1:0] wb_write_data,
  input  logic            ex_md_valid,
  input  logic [2:0]      ex_md_op,
  input  logic            ex_flush,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            md_stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_result_valid
);

  md_state_e        state_q;
  md_op_e           op_q, op_in;
  logic [CNT_W-1:0] count_q;
  logic             sa_q, sb_q, spec_q;
  logic [XLEN-1:0]  res_q;

  logic             start, a_signed, b_signed, sa_d, sb_d;
  logic             div0, ovf, special;
  logic [XLEN-1:0]  a_mag, b_mag, spec_res, core_hi, core_lo, core_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    case (forwardA)
      FWD_EX_MEM: op_a = me_alu_result;
      FWD_MEM_WB: op_a = wb_write_data;
      default:    op_a = id_ex_rs1_data;
    endcase
    case (forwardB)
      FWD_EX_MEM: op_b = me_alu_result;
      FWD_MEM_WB: op_b = wb_write_data;
      default:    op_b = id_ex_rs2_data;
    endcase
  end

  assign op_in    = md_op_e'(ex_md_op);
  assign start    = rst_n && (state_q == ST_IDLE) && ex_md_valid && !ex_flush;
  assign a_signed = (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                    (op_in == MD_DIV)  || (op_in == MD_REM);
  assign b_signed = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
  assign sa_d     = a_signed && op_a[XLEN-1];
  assign sb_d     = b_signed && op_b[XLEN-1];
  assign a_mag    = sa_d ? -op_a : op_a;
  assign b_mag    = sb_d ? -op_b : op_b;

  // Divide-by-zero and signed overflow skip the iteration entirely.
  assign div0     = ex_md_op[2] && (op_b == '0);
  assign ovf      = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign special  = div0 || ovf;
  assign spec_res = div0 ? (ex_md_op[1] ? op_a : '1)
                         : (ex_md_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (start && !special),
    .step_i    ((state_q == ST_BUSY) && !ex_flush),
    .div_i     (ex_md_op[2]),
    .lo_init_i (ex_md_op[2] ? a_mag : b_mag),
    .m_init_i  (ex_md_op[2] ? b_mag : a_mag),
    .hi_o      (core_hi),
    .lo_o      (core_lo)
  );

  assign prod     = {core_hi, core_lo};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

  always_comb begin
    case (op_q)
      MD_MUL:                        core_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  core_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               core_res = (sa_q ^ sb_q) ? -core_lo : core_lo;
      default:                       core_res = sa_q ? -core_hi : core_hi;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MUL;
      count_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      spec_q  <= 1'b0;
      res_q   <= '0;
    end else if (ex_flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_md_valid) begin
            op_q    <= op_in;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            count_q <= CNT_W'(XLEN);
            spec_q  <= special;
            if (special) begin
              res_q   <= spec_res;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          count_q <= count_q - 1'b1;
          if (count_q == CNT_W'(1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          res_q   <= md_result;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md_stall        = start || ((state_q == ST_BUSY) && !ex_flush);
  assign md_result_valid = (state_q == ST_DONE) && !ex_flush;
  assign md_result       = ((state_q == ST_DONE) && !spec_q) ? core_res : res_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with a cycle-level behavioural reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  forwardA = 2'b00, forwardB = 2'b00;
  logic [31:0] id_ex_rs1_data = '0, id_ex_rs2_data = '0;
  logic [31:0] me_alu_result = '0, wb_write_data = '0;
  logic        ex_md_valid = 1'b0;
  logic [2:0]  ex_md_op = 3'b000;
  logic        ex_flush = 1'b0;
  logic [31:0] op_a, op_b, md_result;
  logic        md_stall, md_result_valid;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .forwardA(forwardA), .forwardB(forwardB),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .me_alu_result(me_alu_result), .wb_write_data(wb_write_data),
    .ex_md_valid(ex_md_valid), .ex_md_op(ex_md_op), .ex_flush(ex_flush),
    .op_a(op_a), .op_b(op_b), .md_stall(md_stall),
    .md_result(md_result), .md_result_valid(md_result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                      input logic [31:0] me, input logic [31:0] wb);
    if (sel == 2'b10) return me;
    if (sel == 2'b01) return wb;
    return rf;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    ia = $signed(a); ib = $signed(b);
    case (op)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: an op is idle, has some busy cycles left, or is done for one cycle.
  int          m_busy = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_done <= 1'b0;
    end else if (ex_flush) begin
      m_busy <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_done <= 1'b1;
    end else if (ex_md_valid) begin
      m_res <= ref_md(ex_md_op, fwd(forwardA, id_ex_rs1_data, me_alu_result, wb_write_data),
                      fwd(forwardB, id_ex_rs2_data, me_alu_result, wb_write_data));
      if (is_special(ex_md_op, fwd(forwardA, id_ex_rs1_data, me_alu_result, wb_write_data),
                     fwd(forwardB, id_ex_rs2_data, me_alu_result, wb_write_data)))
        m_done <= 1'b1;
      else
        m_busy <= 32;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_op_a", op_a, fwd(forwardA, id_ex_rs1_data, me_alu_result, wb_write_data));
      chk("cmp_op_b", op_b, fwd(forwardB, id_ex_rs2_data, me_alu_result, wb_write_data));
      chk("cmp_md_stall", {31'd0, md_stall},
          {31'd0, !ex_flush && ((m_busy == 0 && !m_done && ex_md_valid) || m_busy > 0)});
      chk("cmp_md_result_valid", {31'd0, md_result_valid}, {31'd0, m_done && !ex_flush});
      if (m_done && !ex_flush) chk("cmp_md_result", md_result, m_res);
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stalls,
                        input bit perturb);
    int  stalls;
    bit  got;
    stalls = 0;
    got = 1'b0;
    forwardA = 2'b00; forwardB = 2'b00;
    id_ex_rs1_data = a; id_ex_rs2_data = b;
    ex_md_op = op;
    ex_md_valid = 1'b1;
    for (int c = 0; c < 45 && !got; c++) begin
      @(negedge clk);
      if (md_stall) stalls++;
      if (md_result_valid) begin
        got = 1'b1;
        chk(name, md_result, exp);
        chk({name, "_stalls"}, stalls, exp_stalls);
      end
      if (perturb && c == 5) begin
        id_ex_rs1_data = a + 32'd123;
        id_ex_rs2_data = b ^ 32'h55;
        me_alu_result  = 32'hDEAD_BEEF;
        forwardA = 2'b10;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: md_result_valid not seen within 45 cycles", name);
    end
    ex_md_valid = 1'b0;
    forwardA = 2'b00;
    @(negedge clk);
    chk({name, "_hold"}, md_result, exp);
    chk({name, "_idle_stall"}, {31'd0, md_stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("reset_stall", {31'd0, md_stall}, 32'd0);
    chk("reset_valid", {31'd0, md_result_valid}, 32'd0);
    chk("reset_result", md_result, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    forwardA = 2'b10; forwardB = 2'b01;
    me_alu_result = 32'd5; wb_write_data = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mux_op_a", op_a, 32'd5);
      chk("mux_op_b", op_b, 32'd7);
      chk("mux_no_stall", {31'd0, md_stall}, 32'd0);
    end
    @(posedge clk); #1;

    run_op("mul_neg3x7",   3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulh_neg3x7",  3'b001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("mulhu_neg3x7", 3'b011, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 33, 1'b0);
    run_op("mulh_m1xm1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
    run_op("mulhsu_m1xff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_100_7",   3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    run_op("remu_100_7",   3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    run_op("div_by0",      3'b100, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem_by0",      3'b110, 32'h1234, 32'd0, 32'h0000_1234, 1, 1'b0);
    run_op("divu_by0",     3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_by0",     3'b111, 32'h1234, 32'd0, 32'h0000_1234, 1, 1'b0);
    run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);

    // Flush at T+10 of a DIVU.
    ex_md_op = 3'b101; id_ex_rs1_data = 32'd100; id_ex_rs2_data = 32'd7; ex_md_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    ex_flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, md_stall}, 32'd0);
    chk("flush_valid", {31'd0, md_result_valid}, 32'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_md_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_flush_valid", {31'd0, md_result_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Flush coincident with a start must not start.
    ex_md_op = 3'b000; id_ex_rs1_data = 32'd3; id_ex_rs2_data = 32'd4;
    ex_md_valid = 1'b1; ex_flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk); #1;
    ex_md_valid = 1'b0; ex_flush = 1'b0;
    @(negedge clk);
    chk("flush_start_idle", {31'd0, md_stall}, 32'd0);
    @(posedge clk); #1;

    run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    ex_md_op = 3'b000; id_ex_rs1_data = 32'd9; id_ex_rs2_data = 32'd9; ex_md_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, md_stall}, 32'd0);
    chk("rst_mid_valid", {31'd0, md_result_valid}, 32'd0);
    chk("rst_mid_result", md_result, 32'd0);
    ex_md_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mul_after_rst", 3'b000, 32'd6, 32'd7, 32'd42, 33, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
